rfin_packet_rx: RTL and testbench

RFIN_PACKET_RX -- requirements
Module: rfin_packet_rx

---
 rtl/rfin_rx_pkg.sv | 17 +
 rtl/rfin_sync_edge.sv | 24 ++
 rtl/rfin_packet_rx.sv | 209 ++++++++++++++++++++
 tb/tb_rfin_packet_rx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rfin_rx_pkg.sv
// Shared defaults and FSM state encoding for the RF pulse packet receiver.
package rfin_rx_pkg;

  localparam int DEF_PACKET_SIZE   = 24;
  localparam int DEF_PREAMBLE_BITS = 8;
  localparam int DEF_NOM_PERIOD    = 10000;
  localparam int DEF_TOL           = 2500;
  localparam int DEF_CNT_W         = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_LATCH    = 2'd3
  } rx_state_e;

endpackage

// File: rtl/rfin_sync_edge.sv
// Two-flop synchronizer for the asynchronous RF pulse input, followed by a
// rising-edge detector. The edge pulse is valid for the cycle after the
// second synchronizer stage captures the rise.
module rfin_sync_edge (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic din,
  output logic edge_pulse
);

  logic [2:0] sh_q;

  // Shift the raw input through two sync stages plus one history stage.
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      sh_q <= '0;
    end else begin
      sh_q <= {sh_q[1:0], din};
    end
  end

  assign edge_pulse = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/rfin_packet_rx.sv
// RF pulse packet receiver: locks on a run of '1' slots, tracks the slot
// period, decodes pulse/no-pulse slots into bits and latches whole packets
// into a byte buffer that is drained one byte per read strobe.
//
// state       | meaning
// ------------+-------------------------------------------------------
// ST_IDLE     | waiting for the first pulse of a preamble
// ST_PREAMBLE | counting in-window preamble pulses, refining period p
// ST_DATA     | decoding payload bits against the tracked period
// ST_LATCH    | one cycle: copy shift register into the read buffer
module rfin_packet_rx
  import rfin_rx_pkg::*;
#(
  parameter int PACKET_SIZE   = DEF_PACKET_SIZE,
  parameter int PREAMBLE_BITS = DEF_PREAMBLE_BITS,
  parameter int NOM_PERIOD    = DEF_NOM_PERIOD,
  parameter int TOL           = DEF_TOL,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic       i_PCLK,
  input  logic       i_PRESETn,
  input  logic       rfin,
  input  logic       i_rx_en,
  input  logic       i_rd,
  output logic [7:0] o_rx_byte,
  output logic       o_pkt_rec,
  output logic       o_err
);

  localparam int NBYTES = PACKET_SIZE / 8;
  localparam int PTR_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int ONES_W = $clog2(PREAMBLE_BITS + 1);
  localparam int BIT_W  = $clog2(PACKET_SIZE + 1);

  localparam logic [CNT_W-1:0] NOM_C    = CNT_W'(NOM_PERIOD);
  localparam logic [CNT_W-1:0] PRE_LO   = CNT_W'(NOM_PERIOD - TOL);
  localparam logic [CNT_W-1:0] PRE_HI   = CNT_W'(NOM_PERIOD + TOL);
  localparam logic [CNT_W-1:0] TOL_C    = CNT_W'(TOL);
  localparam logic [CNT_W:0]   TOL_X    = (CNT_W + 1)'(TOL);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NBYTES - 1);

  rx_state_e                state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [CNT_W-1:0]         p_q;
  logic [ONES_W-1:0]        ones_q;
  logic [BIT_W-1:0]         bitcnt_q;
  logic [PACKET_SIZE-1:0]   shreg_q;
  logic [PACKET_SIZE-1:0]   buf_q;
  logic [PTR_W-1:0]         rd_ptr_q;
  logic                     pkt_rec_q;
  logic                     err_q;

  logic                     edge_evt;
  logic [CNT_W-1:0]         cnt_inc;
  logic signed [CNT_W:0]    p_s;
  logic signed [CNT_W:0]    p_diff;
  logic signed [CNT_W:0]    p_adj;
  logic [CNT_W-1:0]         p_upd;
  logic                     pre_in_win;
  logic                     pre_late;
  logic                     data_early;
  logic                     data_timeout;
  logic                     rd_ok;

  rfin_sync_edge u_sync (
    .clk_sys    (i_PCLK),
    .rst_b      (i_PRESETn),
    .din        (rfin),
    .edge_pulse (edge_evt)
  );

  // Slot-window decisions, period-tracking update and read qualification.
  always_comb begin
    cnt_inc      = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    p_s          = $signed({1'b0, p_q});
    p_diff       = $signed({1'b0, cnt_q}) - p_s;
    p_adj        = p_s + (p_diff >>> 2);
    // A negative estimate cannot occur with sane parameters; clamp anyway.
    p_upd        = p_adj[CNT_W] ? '0 : p_adj[CNT_W-1:0];
    pre_in_win   = (cnt_q >= PRE_LO) && (cnt_q <= PRE_HI);
    pre_late     = cnt_q > PRE_HI;
    data_early   = ({1'b0, cnt_q} + TOL_X) < {1'b0, p_q};
    data_timeout = {1'b0, cnt_q} == ({1'b0, p_q} + TOL_X);
    // A read landing on the latch cycle is dropped: the new packet wins.
    rd_ok        = i_rd && pkt_rec_q && (state_q != ST_LATCH);
  end

  // Receive FSM, read pointer and registered status outputs.
  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      p_q       <= NOM_C;
      ones_q    <= '0;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      buf_q     <= '0;
      rd_ptr_q  <= '0;
      pkt_rec_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;

      if (rd_ok) begin
        if (rd_ptr_q == LAST_PTR) begin
          rd_ptr_q  <= '0;
          pkt_rec_q <= 1'b0;
        end else begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end

      if (!i_rx_en) begin
        // Disabling drops any packet in flight, including one about to latch.
        state_q  <= ST_IDLE;
        cnt_q    <= '0;
        p_q      <= NOM_C;
        ones_q   <= '0;
        bitcnt_q <= '0;
        shreg_q  <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (edge_evt) begin
              state_q <= ST_PREAMBLE;
              ones_q  <= ONES_W'(1);
              cnt_q   <= '0;
              p_q     <= NOM_C;
            end
          end

          ST_PREAMBLE: begin
            cnt_q <= cnt_inc;
            if (edge_evt) begin
              cnt_q <= '0;
              if (pre_in_win) begin
                p_q    <= p_upd;
                ones_q <= ones_q + 1'b1;
                if (ones_q == ONES_W'(PREAMBLE_BITS - 1)) begin
                  state_q  <= ST_DATA;
                  bitcnt_q <= '0;
                  shreg_q  <= '0;
                end
              end else begin
                // Off-grid pulse: treat it as the start of a new preamble.
                ones_q <= ONES_W'(1);
                p_q    <= NOM_C;
              end
            end else if (pre_late) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
              ones_q  <= '0;
            end
          end

          ST_DATA: begin
            cnt_q <= cnt_inc;
            if (edge_evt && data_early) begin
              err_q    <= 1'b1;
              state_q  <= ST_IDLE;
              cnt_q    <= '0;
              ones_q   <= '0;
              bitcnt_q <= '0;
              shreg_q  <= '0;
            end else if (edge_evt || data_timeout) begin
              shreg_q  <= {shreg_q[PACKET_SIZE-2:0], edge_evt};
              // A missing pulse re-anchors on where it should have been.
              cnt_q    <= edge_evt ? '0 : TOL_C;
              bitcnt_q <= bitcnt_q + 1'b1;
              if (bitcnt_q == BIT_W'(PACKET_SIZE - 1)) begin
                state_q <= ST_LATCH;
              end
            end
          end

          ST_LATCH: begin
            buf_q     <= shreg_q;
            rd_ptr_q  <= '0;
            pkt_rec_q <= 1'b1;
            if (pkt_rec_q) begin
              err_q <= 1'b1;
            end
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ones_q   <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
          end

          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Present the buffer byte selected by the read pointer; byte 0 is oldest.
  always_comb begin
    o_rx_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (rd_ptr_q == PTR_W'(i)) begin
        o_rx_byte = buf_q[PACKET_SIZE-1-8*i -: 8];
      end
    end
  end

  assign o_pkt_rec = pkt_rec_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_rfin_packet_rx.sv
// Bench for rfin_packet_rx. Slot timing is scaled down (100-cycle slots,
// 25-cycle tolerance) so complete packets fit in a short run; pulses are one
// clock wide at the slot centre.
module tb_rfin_packet_rx;

  localparam int PACKET_SIZE   = 24;
  localparam int PREAMBLE_BITS = 8;
  localparam int NOM_PERIOD    = 100;
  localparam int TOL           = 25;
  localparam int CNT_W         = 16;
  localparam int NBYTES        = PACKET_SIZE / 8;
  localparam int SLOT          = NOM_PERIOD;

  typedef logic [7:0] byte_q_t [$];

  typedef struct {
    logic [PACKET_SIZE-1:0] payload;
    bit                     jitter;
    logic [7:0]             exp0;
    logic [7:0]             exp1;
    logic [7:0]             exp2;
  } vec_t;

  logic       i_PCLK    = 1'b0;
  logic       i_PRESETn = 1'b0;
  logic       rfin      = 1'b0;
  logic       i_rx_en   = 1'b0;
  logic       i_rd      = 1'b0;
  logic [7:0] o_rx_byte;
  logic       o_pkt_rec;
  logic       o_err;

  int n_checks       = 0;
  int n_fail         = 0;
  int cyc            = 0;
  int err_cnt        = 0;
  int err_long       = 0;
  int pkt_rise_cyc   = -1;
  int last_pulse_cyc = -1;
  logic err_prev     = 1'b0;
  logic pkt_prev     = 1'b0;

  rfin_packet_rx #(
    .PACKET_SIZE   (PACKET_SIZE),
    .PREAMBLE_BITS (PREAMBLE_BITS),
    .NOM_PERIOD    (NOM_PERIOD),
    .TOL           (TOL),
    .CNT_W         (CNT_W)
  ) dut (
    .i_PCLK    (i_PCLK),
    .i_PRESETn (i_PRESETn),
    .rfin      (rfin),
    .i_rx_en   (i_rx_en),
    .i_rd      (i_rd),
    .o_rx_byte (o_rx_byte),
    .o_pkt_rec (o_pkt_rec),
    .o_err     (o_err)
  );

  always #50 i_PCLK = ~i_PCLK;

  always @(posedge i_PCLK) cyc <= cyc + 1;

  // Count error pulses, flag any that last longer than one cycle, and note
  // the cycle at which o_pkt_rec rises.
  always @(negedge i_PCLK) begin
    if (o_err) err_cnt <= err_cnt + 1;
    if (o_err && err_prev) err_long <= err_long + 1;
    if (o_pkt_rec && !pkt_prev) pkt_rise_cyc <= cyc;
    err_prev <= o_err;
    pkt_prev <= o_pkt_rec;
  end

  initial begin
    #(64'd100 * 64'd95000);
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bytes the receiver should deliver: the payload bits in transmission
  // order, regrouped eight at a time.
  function automatic byte_q_t model_bytes(input logic [PACKET_SIZE-1:0] payload);
    bit         bits[$];
    byte_q_t    q;
    logic [7:0] acc;
    for (int i = PACKET_SIZE - 1; i >= 0; i--) bits.push_back(payload[i]);
    while (bits.size() >= 8) begin
      acc = '0;
      for (int k = 0; k < 8; k++) acc = {acc[6:0], bits.pop_front()};
      q.push_back(acc);
    end
    return q;
  endfunction

  // Bell-shaped offset in [-10, +10] cycles (10% of a slot).
  function automatic int gauss_jit();
    int s;
    s = 0;
    for (int k = 0; k < 4; k++) s += int'($urandom_range(0, 5));
    return s - 10;
  endfunction

  task automatic pulse_seg(input int ncyc, input int pos);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge i_PCLK);
      rfin = (c == pos);
      if (c == pos) last_pulse_cyc = cyc;
    end
  endtask

  task automatic send_slot(input bit b, input int jit);
    pulse_seg(SLOT, b ? (SLOT / 2 + jit) : -1);
  endtask

  task automatic idle_slots(input int n);
    for (int k = 0; k < n; k++) send_slot(1'b0, 0);
  endtask

  // Preamble stays on the nominal grid so the period estimate settles at the
  // true slot length; optional jitter is applied to data pulses.
  task automatic send_packet(input logic [PACKET_SIZE-1:0] payload, input bit jitter, input int ndata);
    for (int k = 0; k < PREAMBLE_BITS; k++) send_slot(1'b1, 0);
    for (int i = 0; i < ndata; i++) send_slot(payload[PACKET_SIZE-1-i], jitter ? gauss_jit() : 0);
  endtask

  task automatic pop_check(input byte_q_t exp, input string tag);
    @(negedge i_PCLK);
    for (int i = 0; i < NBYTES; i++) begin
      check($sformatf("%s_byte%0d", tag, i), {24'd0, o_rx_byte}, {24'd0, exp[i]});
      check($sformatf("%s_pkt_rec_before_pop%0d", tag, i), {31'd0, o_pkt_rec}, 32'd1);
      i_rd = 1'b1;
      @(negedge i_PCLK);
      i_rd = 1'b0;
    end
    check($sformatf("%s_pkt_rec_after_pops", tag), {31'd0, o_pkt_rec}, 32'd0);
  endtask

  initial begin
    vec_t                   vecs [5];
    byte_q_t                exp;
    int                     e0;
    logic [PACKET_SIZE-1:0] pl;

    vecs[0] = '{24'hA5C30F, 1'b0, 8'hA5, 8'hC3, 8'h0F};
    vecs[1] = '{24'h000001, 1'b1, 8'h00, 8'h00, 8'h01};
    vecs[2] = '{24'hFFFFFF, 1'b0, 8'hFF, 8'hFF, 8'hFF};
    vecs[3] = '{24'h800000, 1'b1, 8'h80, 8'h00, 8'h00};
    vecs[4] = '{24'h000000, 1'b0, 8'h00, 8'h00, 8'h00};

    // Reset state.
    repeat (3) @(negedge i_PCLK);
    check("rst_rx_byte", {24'd0, o_rx_byte}, 32'd0);
    check("rst_pkt_rec", {31'd0, o_pkt_rec}, 32'd0);
    check("rst_err", {31'd0, o_err}, 32'd0);
    i_PRESETn = 1'b1;
    i_rx_en   = 1'b1;
    repeat (5) @(negedge i_PCLK);

    // Fixed vectors: nominal, jittered trailing-zero payload, corners.
    for (int v = 0; v < 5; v++) begin
      e0 = err_cnt;
      send_packet(vecs[v].payload, vecs[v].jitter, PACKET_SIZE);
      idle_slots(2);
      check($sformatf("vec%0d_no_err", v), err_cnt - e0, 32'd0);
      if (vecs[v].payload[0])
        check($sformatf("vec%0d_pkt_rec_latency", v), pkt_rise_cyc - last_pulse_cyc, 32'd4);
      exp = '{vecs[v].exp0, vecs[v].exp1, vecs[v].exp2};
      pop_check(exp, $sformatf("vec%0d", v));
    end

    // Random payloads with jittered data pulses against the byte model.
    for (int r = 0; r < 4; r++) begin
      pl = PACKET_SIZE'($urandom());
      e0 = err_cnt;
      send_packet(pl, 1'b1, PACKET_SIZE);
      idle_slots(2);
      check($sformatf("rand%0d_no_err", r), err_cnt - e0, 32'd0);
      pop_check(model_bytes(pl), $sformatf("rand%0d", r));
    end

    // Short interval: a data pulse 40 cycles after the preamble anchor.
    e0 = err_cnt;
    for (int k = 0; k < PREAMBLE_BITS - 1; k++) send_slot(1'b1, 0);
    pulse_seg(60, 50);
    pulse_seg(40, 30);
    idle_slots(2);
    check("short_err_count", err_cnt - e0, 32'd1);
    check("short_no_pkt_rec", {31'd0, o_pkt_rec}, 32'd0);
    e0 = err_cnt;
    send_packet(24'h0F0F0F, 1'b0, PACKET_SIZE);
    idle_slots(2);
    check("post_short_no_err", err_cnt - e0, 32'd0);
    pop_check(model_bytes(24'h0F0F0F), "post_short");

    // Overrun: two packets with no reads in between.
    e0 = err_cnt;
    send_packet(24'h112233, 1'b0, PACKET_SIZE);
    idle_slots(2);
    check("ovr_first_no_err", err_cnt - e0, 32'd0);
    send_packet(24'hDEAD42, 1'b0, PACKET_SIZE);
    idle_slots(2);
    check("ovr_err_count", err_cnt - e0, 32'd1);
    pop_check(model_bytes(24'hDEAD42), "ovr");

    // Asynchronous reset at data bit 10 with an unread packet buffered.
    send_packet(24'h5A1234, 1'b0, PACKET_SIZE);
    idle_slots(2);
    send_packet(24'hFF00FF, 1'b0, 10);
    repeat (20) @(negedge i_PCLK);
    check("pre_rst_pkt_rec", {31'd0, o_pkt_rec}, 32'd1);
    check("pre_rst_rx_byte", {24'd0, o_rx_byte}, 32'h5A);
    #10;
    i_PRESETn = 1'b0;
    #1;
    check("mid_rst_rx_byte", {24'd0, o_rx_byte}, 32'd0);
    check("mid_rst_pkt_rec", {31'd0, o_pkt_rec}, 32'd0);
    check("mid_rst_err", {31'd0, o_err}, 32'd0);
    repeat (5) @(negedge i_PCLK);
    i_PRESETn = 1'b1;
    idle_slots(1);
    e0 = err_cnt;
    send_packet(24'hC0FFEE, 1'b0, PACKET_SIZE);
    idle_slots(2);
    check("post_rst_no_err", err_cnt - e0, 32'd0);
    pop_check(model_bytes(24'hC0FFEE), "post_rst");

    // Receiver disabled for a whole packet: buffer and flag left alone.
    e0 = err_cnt;
    send_packet(24'h3C5A96, 1'b0, PACKET_SIZE);
    idle_slots(2);
    @(negedge i_PCLK);
    i_rx_en = 1'b0;
    send_packet(24'h123456, 1'b0, PACKET_SIZE);
    idle_slots(2);
    check("dis_no_err", err_cnt - e0, 32'd0);
    check("dis_pkt_rec_kept", {31'd0, o_pkt_rec}, 32'd1);
    i_rx_en = 1'b1;
    idle_slots(1);
    pop_check(model_bytes(24'h3C5A96), "dis");

    repeat (3) @(negedge i_PCLK);
    check("err_pulse_width", err_long, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
